// File: rtl/counter_pkg.sv
// counter_pkg
// Constants and helpers shared by the multi-channel strobe counter and its
// per-channel sub-module.
//   MODE_PERIODIC / MODE_ONESHOT : encoding of the per-channel mode bit
//   COUNTER_RESET_VALUE          : value a counter restarts from
//   sel_width()                  : width of a channel select, never below 1
package counter_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int COUNTER_RESET_VALUE = 1;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/strobe_counter_channel.sv
// strobe_counter_channel
// One channel: reloadable period, periodic/one-shot mode, armed flag, counter
// and a registered one-cycle strobe raised the cycle after the terminal tick.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : count enable for this channel
//   load       : capture period_in/mode_in and restart the count
//   period_in  : new period (sampled on load)
//   mode_in    : new mode (sampled on load)
//   sync_clr   : restart the count, keep configuration and armed
//   count      : current counter value
//   armed      : a future tick can still produce a strobe
//   strobe     : one-cycle terminal-count pulse
module strobe_counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             mode_in,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] count,
    output logic             armed,
    output logic             strobe
);

    localparam logic [WIDTH-1:0] COUNT_INIT = WIDTH'(COUNTER_RESET_VALUE);
    localparam logic [WIDTH-1:0] COUNT_STEP = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q,   mode_d;
    logic             armed_q,  armed_d;
    logic             strobe_q, strobe_d;

    // Next-state selection: load beats sync_clr beats a tick; otherwise hold.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        armed_d  = armed_q;
        strobe_d = 1'b0;
        if (load) begin
            period_d = period_in;
            mode_d   = mode_in;
            count_d  = COUNT_INIT;
            // A zero period can never reach its terminal count.
            armed_d  = (period_in != {WIDTH{1'b0}});
        end else if (sync_clr) begin
            count_d = COUNT_INIT;
        end else if (tick && armed_q) begin
            if (count_q == period_q) begin
                count_d  = COUNT_INIT;
                strobe_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    armed_d = 1'b0;
                end else begin
                    armed_d = armed_q;
                end
            end else begin
                // count_q never exceeds period_q here, so no wrap in practice.
                count_d = count_q + COUNT_STEP;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= COUNT_INIT;
            period_q <= {WIDTH{1'b0}};
            mode_q   <= MODE_PERIODIC;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            strobe_q <= strobe_d;
        end
    end

    assign count  = count_q;
    assign armed  = armed_q;
    assign strobe = strobe_q;

endmodule

// File: rtl/multi_channel_strobe_counter.sv
// multi_channel_strobe_counter
// CHANNELS independent strobe counters sharing one clock, one period/mode
// input bus and one synchronous clear. Each strobe can be delayed by LATENCY
// extra register stages; count readback has one cycle of latency.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   enable    : per-channel count tick
//   load      : per-channel configuration load
//   period_in : shared period value, sampled on load
//   mode_in   : shared mode (0 periodic, 1 one-shot), sampled on load
//   sync_clr  : restart every counter at 1
//   strobe    : per-channel terminal-count pulse after 1+LATENCY cycles
//   armed     : per-channel "will strobe again" flag
//   rd_sel    : channel to read back
//   rd_count  : registered count of rd_sel, 0 when rd_sel is out of range
module multi_channel_strobe_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 25,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              enable,
    input  logic [CHANNELS-1:0]              load,
    input  logic [WIDTH-1:0]                 period_in,
    input  logic                             mode_in,
    input  logic                             sync_clr,
    output logic [CHANNELS-1:0]              strobe,
    output logic [CHANNELS-1:0]              armed,
    input  logic [sel_width(CHANNELS)-1:0]   rd_sel,
    output logic [WIDTH-1:0]                 rd_count
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS-1:0] strobe_int_s;
    logic [WIDTH-1:0]    count_s [CHANNELS];
    logic [CHANNELS-1:0] stage_s [0:LATENCY];
    logic [WIDTH-1:0]    rd_count_q, rd_count_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        strobe_counter_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (enable[g]),
            .load      (load[g]),
            .period_in (period_in),
            .mode_in   (mode_in),
            .sync_clr  (sync_clr),
            .count     (count_s[g]),
            .armed     (armed[g]),
            .strobe    (strobe_int_s[g])
        );
    end

    // Stage 0 is the channel's own registered strobe; each further stage adds
    // one cycle. Load and sync_clr do not touch these, so queued pulses emerge.
    assign stage_s[0] = strobe_int_s;

    for (genvar s = 1; s <= LATENCY; s++) begin : g_pipe
        logic [CHANNELS-1:0] stage_q, stage_d;

        // Next value of this delay stage.
        always_comb begin
            stage_d = stage_s[s-1];
        end

        // Delay stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= {CHANNELS{1'b0}};
            end else begin
                stage_q <= stage_d;
            end
        end

        assign stage_s[s] = stage_q;
    end

    assign strobe = stage_s[LATENCY];

    // Readback mux built as an OR of one-hot matches so unused select codes
    // naturally return zero.
    always_comb begin
        rd_count_d = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            rd_count_d = rd_count_d |
                         ((rd_sel == SEL_W'(i)) ? count_s[i] : {WIDTH{1'b0}});
        end
    end

    // Readback register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= {WIDTH{1'b0}};
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_multi_channel_strobe_counter.sv
// Bench for multi_channel_strobe_counter: two instances, LATENCY 0 (dut0) and
// LATENCY 3 (dut3). Expected strobe words are queued when stimulus is driven
// and popped when the matching output cycle arrives.
module tb_multi_channel_strobe_counter;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk;
    logic          rst;

    logic [CH-1:0] en0, ld0, strb0, arm0;
    logic [W-1:0]  per0, rdc0;
    logic          mode0, clr0;
    logic [1:0]    sel0;

    logic [CH-1:0] en3, ld3, strb3, arm3;
    logic [W-1:0]  per3, rdc3;
    logic          mode3, clr3;
    logic [1:0]    sel3;

    int checks;
    int errors;

    typedef struct {
        string         tag;
        logic [CH-1:0] s;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    multi_channel_strobe_counter #(.WIDTH(W), .CHANNELS(CH), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .load(ld0), .period_in(per0),
        .mode_in(mode0), .sync_clr(clr0), .strobe(strb0), .armed(arm0),
        .rd_sel(sel0), .rd_count(rdc0)
    );

    multi_channel_strobe_counter #(.WIDTH(W), .CHANNELS(CH), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .enable(en3), .load(ld3), .period_in(per3),
        .mode_in(mode3), .sync_clr(clr3), .strobe(strb3), .armed(arm3),
        .rd_sel(sel3), .rd_count(rdc3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk4(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill3();
        exp_t f;
        f.tag = "pipe_fill";
        f.s   = 4'b0000;
        q3.delete();
        repeat (3) q3.push_back(f);
    endtask

    // Push the internal-strobe expectation of this edge for both instances,
    // clock once, then compare each output against the entry now due.
    task automatic step(input string tag, input logic [CH-1:0] e0, input logic [CH-1:0] e3);
        exp_t a;
        exp_t b;
        a.tag = tag; a.s = e0; q0.push_back(a);
        b.tag = tag; b.s = e3; q3.push_back(b);
        @(posedge clk);
        #1;
        a = q0.pop_front();
        b = q3.pop_front();
        chk4($sformatf("strobe0 %s", a.tag), strb0, a.s);
        chk4($sformatf("strobe3 %s", b.tag), strb3, b.s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en0 = 4'b0000; ld0 = 4'b0000; per0 = 8'd0; mode0 = 1'b0; clr0 = 1'b0; sel0 = 2'd3;
        en3 = 4'b0000; ld3 = 4'b0000; per3 = 8'd0; mode3 = 1'b0; clr3 = 1'b0; sel3 = 2'd0;
        fill3();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk4("rst strobe0", strb0, 4'b0000);
        chk4("rst armed0", arm0, 4'b0000);
        chk8("rst rd0", rdc0, 8'd0);
        chk4("rst strobe3", strb3, 4'b0000);
        chk4("rst armed3", arm3, 4'b0000);
        chk8("rst rd3", rdc3, 8'd0);
        rst = 1'b0;

        // Edge periods: ch3 period 0, ch2 period 1; then ch0 period 5 periodic
        ld0 = 4'b1000; per0 = 8'd0;
        step("load ch3 p0", 4'b0000, 4'b0000);
        chk4("p0 not armed", arm0, 4'b0000);
        chk8("ch3 rd initial", rdc0, 8'd1);
        ld0 = 4'b0100; per0 = 8'd1;
        step("load ch2 p1", 4'b0000, 4'b0000);
        chk4("p1 armed", arm0, 4'b0100);
        ld0 = 4'b0001; per0 = 8'd5; en0 = 4'b1101;
        step("load ch0 p5", 4'b0100, 4'b0000);
        chk4("p5 armed", arm0, 4'b0101);
        ld0 = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            step("periodic", {1'b0, 1'b1, 1'b0, (k % 5 == 0)}, 4'b0000);
            chk4("periodic armed", arm0, 4'b0101);
        end
        chk8("ch3 rd stays 1", rdc0, 8'd1);

        // One-shot ch1 period 3 with toggled enable
        en0 = 4'b0000; ld0 = 4'b0010; per0 = 8'd3; mode0 = 1'b1; sel0 = 2'd1;
        step("load ch1 oneshot", 4'b0000, 4'b0000);
        chk4("oneshot armed", arm0, 4'b0111);
        ld0 = 4'b0000; mode0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            en0 = (k % 2 == 1) ? 4'b0010 : 4'b0000;
            step("oneshot", (k == 5) ? 4'b0010 : 4'b0000, 4'b0000);
            chk4("oneshot armed seq", arm0, (k >= 5) ? 4'b0101 : 4'b0111);
        end
        en0 = 4'b0010;
        repeat (10) step("oneshot spent", 4'b0000, 4'b0000);
        chk4("oneshot stays disarmed", arm0, 4'b0101);
        chk8("oneshot rd", rdc0, 8'd1);

        // Priority: load with a terminal tick on ch0
        sel0 = 2'd0; en0 = 4'b0001;
        repeat (4) step("advance ch0", 4'b0000, 4'b0000);
        ld0 = 4'b0001; per0 = 8'd7;
        step("load beats tick", 4'b0000, 4'b0000);
        chk8("rd before load", rdc0, 8'd5);
        ld0 = 4'b0000; en0 = 4'b0000;
        step("idle after load", 4'b0000, 4'b0000);
        chk8("rd after load", rdc0, 8'd1);
        en0 = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step("period7", {3'b000, (k == 7)}, 4'b0000);
        end
        chk4("period7 armed", arm0, 4'b0101);

        // sync_clr at counter 4, period 5 retained
        en0 = 4'b0000; ld0 = 4'b0001; per0 = 8'd5;
        step("reload p5", 4'b0000, 4'b0000);
        ld0 = 4'b0000; en0 = 4'b0001;
        repeat (3) step("advance to 4", 4'b0000, 4'b0000);
        clr0 = 1'b1;
        step("sync_clr", 4'b0000, 4'b0000);
        chk8("rd at clr", rdc0, 8'd4);
        chk4("clr keeps armed", arm0, 4'b0101);
        clr0 = 1'b0; en0 = 4'b0000;
        step("after clr", 4'b0000, 4'b0000);
        chk8("rd 1 after clr", rdc0, 8'd1);
        en0 = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step("period kept 5", {3'b000, (k == 5)}, 4'b0000);
        end

        // Maximum period on ch3
        en0 = 4'b0000; ld0 = 4'b1000; per0 = 8'd255; sel0 = 2'd3;
        step("load ch3 p255", 4'b0000, 4'b0000);
        chk4("p255 armed", arm0, 4'b1101);
        ld0 = 4'b0000; en0 = 4'b1000;
        for (int k = 1; k <= 255; k++) begin
            step("p255", {(k == 255), 3'b000}, 4'b0000);
        end
        chk8("rd at 255", rdc0, 8'd255);
        en0 = 4'b0000;
        step("p255 idle", 4'b0000, 4'b0000);
        chk8("rd after 255", rdc0, 8'd1);
        chk4("p255 still armed", arm0, 4'b1101);

        // LATENCY 3: period 2, sync_clr with a pulse in flight
        ld3 = 4'b0001; per3 = 8'd2; mode3 = 1'b0; en3 = 4'b0001;
        step("d3 load", 4'b0000, 4'b0000);
        chk4("d3 armed", arm3, 4'b0001);
        ld3 = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            step("d3 tick", 4'b0000, {3'b000, (k % 2 == 0)});
        end
        clr3 = 1'b1;
        step("d3 clr", 4'b0000, 4'b0000);
        clr3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step("d3 after clr", 4'b0000, {3'b000, (k % 2 == 0)});
        end
        chk4("d3 strobe before rst", strb3, 4'b0001);
        chk8("d3 rd before rst", rdc3, 8'd1);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk4("async rst strobe3", strb3, 4'b0000);
        chk4("async rst armed3", arm3, 4'b0000);
        chk8("async rst rd3", rdc3, 8'd0);
        chk4("async rst armed0", arm0, 4'b0000);
        #2 rst = 1'b0;
        fill3();
        en0 = 4'b1111;
        step("post rst", 4'b0000, 4'b0000);
        chk8("post rst rd3", rdc3, 8'd1);
        chk4("post rst armed3", arm3, 4'b0000);
        repeat (5) step("post rst idle", 4'b0000, 4'b0000);
        chk4("post rst armed3 late", arm3, 4'b0000);
        chk4("post rst armed0 late", arm0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
